// File: rtl/serial_rx_deser.sv
// Serial-to-parallel receiver: rebuilds a WORDS x WIDTH-bit frame from a strobed bit
// stream and holds it under a valid/ack handshake with overrun and gap-timeout flags.
module serial_rx_deser #(
    parameter int WIDTH   = 4,
    parameter int WORDS   = 2,
    parameter int TIMEOUT = 8
) (
    input  logic                   ck,
    input  logic                   reset,
    input  logic                   sin,
    input  logic                   sin_vld,
    input  logic                   ack,
    output logic [WIDTH*WORDS-1:0] Dout,
    output logic                   dvalid,
    output logic                   busy,
    output logic                   overrun,
    output logic                   gap_err
);

    localparam int N  = WIDTH * WORDS;
    localparam int CW = $clog2(N + 1);
    localparam int GW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [N-1:0]    shreg_q, shreg_d;
    logic [N-1:0]    dout_q, dout_d;
    logic            dvalid_q, dvalid_d;
    logic            overrun_q, overrun_d;
    logic            gap_err_q, gap_err_d;
    logic [N:0]      shift_ext;
    logic [N-1:0]    shifted;

    // Shift through an N+1 wide vector so the same expression also covers N==1.
    assign shift_ext = {shreg_q, sin};
    assign shifted   = shift_ext[N-1:0];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shreg_d   = shreg_q;
        dout_d    = dout_q;
        dvalid_d  = dvalid_q;
        overrun_d = overrun_q;
        gap_err_d = 1'b0;

        if (dvalid_q && ack)
            dvalid_d = 1'b0;

        if (sin_vld) begin
            shreg_d   = shifted;
            gap_cnt_d = '0;
            if (bit_cnt_q == CW'(N - 1)) begin
                // A completing frame always wins; an un-acked old frame is an overrun.
                dout_d    = shifted;
                dvalid_d  = 1'b1;
                overrun_d = overrun_q | (dvalid_q & ~ack);
                bit_cnt_d = '0;
                state_d   = IDLE;
            end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
                state_d   = RECV;
            end
        end else if (state_q == RECV) begin
            if (gap_cnt_q == GW'(TIMEOUT - 1)) begin
                bit_cnt_d = '0;
                gap_cnt_d = '0;
                shreg_d   = '0;
                gap_err_d = 1'b1;
                state_d   = IDLE;
            end else begin
                gap_cnt_d = gap_cnt_q + GW'(1);
            end
        end
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            shreg_q   <= '0;
            dout_q    <= '0;
            dvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
            gap_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            shreg_q   <= shreg_d;
            dout_q    <= dout_d;
            dvalid_q  <= dvalid_d;
            overrun_q <= overrun_d;
            gap_err_q <= gap_err_d;
        end
    end

    assign Dout    = dout_q;
    assign dvalid  = dvalid_q;
    assign busy    = (state_q == RECV);
    assign overrun = overrun_q;
    assign gap_err = gap_err_q;

endmodule
